// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipe: load-use stall, redirect flush, memory wait.
// Optional HAZARD_STATS_EN adds a saturating stall_count output.
`timescale 1ns/1ps
module pipeline_hazard_ctrl #(
  parameter int FLUSH_DEPTH = 2,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_load,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_rd,
  input  logic       branch_taken,
  input  logic       jalr_ex,
  input  logic       mem_req,
  input  logic       mem_ack,
  output logic       if_en,
  output logic       id_en,
  output logic       ex_en,
  output logic       id_flush,
  output logic       ex_flush,
  output logic       mem_err,
`ifdef HAZARD_STATS_EN
  output logic [15:0] stall_count,
`endif
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    FLUSH    = 2'b01,
    MEM_WAIT = 2'b10
  } state_e;

  localparam logic [2:0] FD_M1 = 3'(FLUSH_DEPTH - 1);
  localparam logic [7:0] TO    = 8'(MEM_TIMEOUT);

  state_e     cur, nxt;
  logic [2:0] fcnt, fcnt_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       load_use, redirect, mem_stall;

  assign load_use  = ex_load & ex_reg_write & (ex_rd != 5'd0) &
                     ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign redirect  = branch_taken | jalr_ex;
  assign mem_stall = mem_req & ~mem_ack;
  assign state     = cur;

  always_comb begin
    nxt      = cur;
    fcnt_nxt = fcnt;
    wcnt_nxt = wcnt;
    if_en    = 1'b1;
    id_en    = 1'b1;
    ex_en    = 1'b1;
    id_flush = 1'b0;
    ex_flush = 1'b0;
    mem_err  = 1'b0;
    case (cur)
      RUN, FLUSH: begin
        if (mem_stall) begin
          // freeze already in the cycle the memory stage first stalls
          if_en    = 1'b0;
          id_en    = 1'b0;
          ex_en    = 1'b0;
          nxt      = MEM_WAIT;
          wcnt_nxt = 8'd0;
          fcnt_nxt = 3'd0;
        end else if (redirect) begin
          id_flush = 1'b1;
          ex_flush = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            nxt      = FLUSH;
            fcnt_nxt = FD_M1;
          end else begin
            nxt      = RUN;
            fcnt_nxt = 3'd0;
          end
        end else if (cur == FLUSH) begin
          id_flush = 1'b1;
          ex_flush = 1'b1;
          if (fcnt <= 3'd1) begin
            nxt      = RUN;
            fcnt_nxt = 3'd0;
          end else begin
            fcnt_nxt = fcnt - 3'd1;
          end
        end else if (load_use) begin
          if_en    = 1'b0;
          id_en    = 1'b0;
          ex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if_en = 1'b0;
        id_en = 1'b0;
        ex_en = 1'b0;
        if (mem_ack) begin
          nxt      = RUN;
          wcnt_nxt = 8'd0;
        end else if (wcnt == TO) begin
          mem_err  = 1'b1;
          nxt      = RUN;
          wcnt_nxt = 8'd0;
        end else begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      default: begin
        nxt      = RUN;
        fcnt_nxt = 3'd0;
        wcnt_nxt = 8'd0;
      end
    endcase
    // reset holds the pipe frozen with bubbles in both stages
    if (rst) begin
      if_en    = 1'b0;
      id_en    = 1'b0;
      ex_en    = 1'b0;
      id_flush = 1'b1;
      ex_flush = 1'b1;
      mem_err  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur  <= RUN;
      fcnt <= 3'd0;
      wcnt <= 8'd0;
    end else begin
      cur  <= nxt;
      fcnt <= fcnt_nxt;
      wcnt <= wcnt_nxt;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= 16'd0;
    end else if (!if_en && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  localparam int FD = 2;
  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       ex_load = 0, ex_reg_write = 0;
  logic       branch_taken = 0, jalr_ex = 0;
  logic       mem_req = 0, mem_ack = 0;
  logic       if_en, id_en, ex_en, id_flush, ex_flush, mem_err;
  logic [1:0] state;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count;
`endif
  logic [7:0] obs;

  int total = 0;
  int bad = 0;

  // model: remaining flush cycles, waiting flag, cycles waited so far
  int m_flush_left = 0;
  bit m_wait = 0;
  int m_waited = 0;
  int m_stalls = 0;

  pipeline_hazard_ctrl #(
    .FLUSH_DEPTH(FD),
    .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .ex_load(ex_load),
    .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd),
    .branch_taken(branch_taken),
    .jalr_ex(jalr_ex),
    .mem_req(mem_req),
    .mem_ack(mem_ack),
    .if_en(if_en),
    .id_en(id_en),
    .ex_en(ex_en),
    .id_flush(id_flush),
    .ex_flush(ex_flush),
    .mem_err(mem_err),
`ifdef HAZARD_STATS_EN
    .stall_count(stall_count),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {if_en, id_en, ex_en, id_flush, ex_flush, mem_err, state};

  // {if_en,id_en,ex_en,id_flush,ex_flush,mem_err,state}
  function automatic logic [7:0] expect_out();
    logic lu, rdr, ms;
    logic [1:0] st;
    lu  = ex_load && ex_reg_write && ex_rd != 5'd0 &&
          (ex_rd == id_rs1 || ex_rd == id_rs2);
    rdr = branch_taken || jalr_ex;
    ms  = mem_req && !mem_ack;
    if (m_wait) begin
      if (!mem_ack && m_waited == TO) return 8'b00000110;
      return 8'b00000010;
    end
    st = (m_flush_left > 0) ? 2'b01 : 2'b00;
    if (ms) return {6'b000000, st};
    if (rdr || m_flush_left > 0) return {6'b111110, st};
    if (lu) return 8'b00101000;
    return 8'b11100000;
  endfunction

  task automatic model_step();
    logic [7:0] e;
    e = expect_out();
    if (!e[7] && m_stalls < 65535) m_stalls++;
    if (m_wait) begin
      if (mem_ack || m_waited == TO) begin
        m_wait = 0;
        m_flush_left = 0;
      end else begin
        m_waited++;
      end
    end else if (mem_req && !mem_ack) begin
      m_wait = 1;
      m_waited = 0;
      m_flush_left = 0;
    end else if (branch_taken || jalr_ex) begin
      m_flush_left = FD - 1;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end
  endtask

  task automatic model_reset();
    m_flush_left = 0;
    m_wait = 0;
    m_waited = 0;
    m_stalls = 0;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic ld, input logic wr,
                       input logic br, input logic jr,
                       input logic mq, input logic ma);
    id_rs1 = rs1;
    id_rs2 = rs2;
    ex_rd = rd;
    ex_load = ld;
    ex_reg_write = wr;
    branch_taken = br;
    jalr_ex = jr;
    mem_req = mq;
    mem_ack = ma;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    total++;
    if (obs !== 8'b00011000) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=%b", obs, 8'b00011000);
    end
`ifdef HAZARD_STATS_EN
    total++;
    if (stall_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_stall_count got=%0d exp=0", stall_count);
    end
`endif
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_load_use();
    logic [7:0] exp_a [4] = '{8'b00101000, 8'b11100000,
                              8'b00101000, 8'b11100000};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(5'd3, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0);
        2: drive(5'd7, 5'd1, 5'd7, 1, 1, 0, 0, 0, 0);
        default: drive(5'd3, 5'd5, 5'd5, 0, 1, 0, 0, 0, 0);
      endcase
      total++;
      if (obs !== exp_a[i]) begin
        bad++;
        $display("FAIL load_use step=%0d got=%b exp=%b", i, obs, exp_a[i]);
      end
      advance();
    end
  endtask

  task automatic test_no_stall_x0();
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive(5'd3, 5'd0, 5'd0, 1, 1, 0, 0, 0, 0);
      else drive(5'd5, 5'd2, 5'd5, 1, 0, 0, 0, 0, 0);
      total++;
      if (obs !== 8'b11100000) begin
        bad++;
        $display("FAIL no_stall step=%0d got=%b exp=%b", i, obs, 8'b11100000);
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    logic [7:0] exp_a [6] = '{8'b11111000, 8'b11111001, 8'b11100000,
                              8'b11111000, 8'b11111001, 8'b11100000};
    for (int i = 0; i < 6; i++) begin
      // load-use coincident with the redirect must not stall
      if (i == 0) drive(5'd4, 5'd0, 5'd4, 1, 1, 1, 0, 0, 0);
      else if (i == 3) drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
      else drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
      total++;
      if (obs !== exp_a[i]) begin
        bad++;
        $display("FAIL redirect step=%0d got=%b exp=%b", i, obs, exp_a[i]);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_a [4] = '{8'b11111000, 8'b11111001,
                              8'b11111001, 8'b11100000};
    for (int i = 0; i < 4; i++) begin
      drive(5'd0, 5'd0, 5'd0, 0, 0, i < 2, 0, 0, 0);
      total++;
      if (obs !== exp_a[i]) begin
        bad++;
        $display("FAIL back_to_back step=%0d got=%b exp=%b", i, obs, exp_a[i]);
      end
      advance();
    end
  endtask

  task automatic test_mem_wait();
    logic [7:0] exp_a [6] = '{8'b11100000, 8'b00000000, 8'b00000010,
                              8'b00000010, 8'b00000010, 8'b11100000};
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1);
        1, 2, 3: drive(5'd2, 5'd2, 5'd2, 1, 1, 1, 0, 1, 0);
        4: drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, 1);
        default: drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
      endcase
      total++;
      if (obs !== exp_a[i]) begin
        bad++;
        $display("FAIL mem_wait step=%0d got=%b exp=%b", i, obs, exp_a[i]);
      end
      advance();
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp_a [7] = '{8'b00000000, 8'b00000010, 8'b00000010,
                              8'b00000010, 8'b00000110, 8'b11100000,
                              8'b11100000};
    for (int i = 0; i < 7; i++) begin
      drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, i < 5, 0);
      total++;
      if (obs !== exp_a[i]) begin
        bad++;
        $display("FAIL timeout step=%0d got=%b exp=%b", i, obs, exp_a[i]);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_flush();
    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
    advance();
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    total++;
    if (state !== 2'b01) begin
      bad++;
      $display("FAIL pre_rst_flush got=%b exp=01", state);
    end
    rst = 1'b1;
    #1;
    total++;
    if (obs !== 8'b00011000) begin
      bad++;
      $display("FAIL rst_mid_flush got=%b exp=%b", obs, 8'b00011000);
    end
`ifdef HAZARD_STATS_EN
    total++;
    if (stall_count !== 16'd0) begin
      bad++;
      $display("FAIL rst_mid_flush_cnt got=%0d exp=0", stall_count);
    end
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs !== 8'b11100000) begin
      bad++;
      $display("FAIL post_rst_run got=%b exp=%b", obs, 8'b11100000);
    end
    advance();
  endtask

  task automatic test_random();
    logic [7:0] e;
    for (int i = 0; i < 600; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 1)));
      e = expect_out();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, obs, e);
      end
      advance();
    end
`ifdef HAZARD_STATS_EN
    total++;
    if (stall_count !== 16'(m_stalls)) begin
      bad++;
      $display("FAIL stall_count got=%0d exp=%0d", stall_count, m_stalls);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall_x0();
    test_redirect();
    test_back_to_back();
    test_mem_wait();
    test_timeout();
    test_reset_mid_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter FLUSH_DEPTH, default 2: number of cycles bubbles are injected after a control redirect; legal range 1..7.
REQ-002 Parameter MEM_TIMEOUT, default 255: maximum number of MEM_WAIT cycles before abort; legal range 1..255.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the instruction in decode.
REQ-006 ex_load, ex_reg_write  in  1 each  decode/execute pipe load flag and write-enable.
REQ-007 ex_rd  in  5  destination register held in the decode/execute pipe.
REQ-008 branch_taken, jalr_ex  in  1 each  control redirect resolved in execute.
REQ-009 mem_req, mem_ack  in  1 each  data-memory request from the memory stage, and its completion.
REQ-010 if_en, id_en, ex_en  out  1 each  pipeline-register load enables; 1 = advance.
REQ-011 id_flush, ex_flush  out  1 each  replace the fetch/decode or decode/execute pipe contents with a NOP bubble.
REQ-012 mem_err  out  1  one-cycle pulse on memory timeout.
REQ-013 state  out  2  encoding RUN=00, FLUSH=01, MEM_WAIT=10.

Function
REQ-014 FSM states are RUN, FLUSH and MEM_WAIT; a 3-bit flush counter and an 8-bit wait counter are the only other state.
REQ-015 Outputs are combinational from state and current inputs; there is no added latency.
REQ-016 RUN, no event: if_en=id_en=ex_en=1, both flushes 0.
REQ-017 Load-use hazard = ex_load & ex_reg_write & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-018 Load-use response in RUN: if_en=id_en=0, ex_en=1, ex_flush=1 for exactly one cycle; state remains RUN.
REQ-019 Redirect (branch_taken|jalr_ex) in RUN: id_flush=ex_flush=1 that cycle, all enables 1.
REQ-020 On a redirect, if FLUSH_DEPTH>1 the FSM enters FLUSH with the counter loaded to FLUSH_DEPTH-1; otherwise it stays in RUN.
REQ-021 FLUSH: id_flush=1, ex_flush=1, all enables 1; the counter decrements each cycle and the FSM returns to RUN when the counter is 1.
REQ-022 A redirect while in FLUSH reloads the counter to FLUSH_DEPTH-1.
REQ-023 mem_req & !mem_ack in RUN or FLUSH enters MEM_WAIT with the wait counter cleared; mem_req & mem_ack in the same cycle causes no stall.
REQ-024 MEM_WAIT: all enables 0, both flushes 0, and redirect and load-use inputs are ignored.
REQ-025 MEM_WAIT exits to RUN on mem_ack; a pending FLUSH count is discarded.
REQ-026 The wait counter increments each MEM_WAIT cycle; when it reaches MEM_TIMEOUT, mem_err pulses for one cycle and the FSM enters RUN.
REQ-027 Entry priority is MEM_WAIT entry > redirect > load-use; a redirect coincident with a load-use produces only the redirect response.
REQ-028 mem_err is 0 in every cycle that is not a timeout.

Reset
REQ-029 rst asserted forces state=RUN and clears both counters immediately, independent of clk, including mid-FLUSH or mid-MEM_WAIT.
REQ-030 While rst is high: if_en=id_en=ex_en=0, id_flush=ex_flush=1, mem_err=0.
REQ-031 The first edge after rst deassertion behaves as RUN.

Configuration
REQ-032 The macro HAZARD_STATS_EN, when defined, adds output stall_count (16 bits): it counts cycles with if_en=0, saturates at 16'hFFFF, and is cleared by rst.
REQ-033 Without HAZARD_STATS_EN, the stall_count port and its counter are absent and all other behaviour is identical.

Verification
REQ-034 ex_load=1, ex_reg_write=1, ex_rd=5, id_rs2=5 -> one cycle with if_en=0, id_en=0, ex_flush=1, then normal RUN.
REQ-035 Same as REQ-034 but ex_rd=0 -> no stall.
REQ-036 branch_taken pulse with FLUSH_DEPTH=2 -> id_flush=1 for 2 cycles (state 00 then 01) and state=00 after.
REQ-037 mem_req=1, mem_ack after 4 cycles, branch_taken high meanwhile -> 4 frozen cycles with no flushes, then RUN.
REQ-038 mem_req held and mem_ack never arrives, MEM_TIMEOUT=3 -> mem_err high for 1 cycle after 3 wait cycles, then state=00.
REQ-039 rst asserted mid-FLUSH between clock edges -> state=00 and enables=0 immediately; with HAZARD_STATS_EN defined, stall_count=0.
